// File: rtl/executor_move_multi.sv
// Multi-step tile move executor: steps the active tile up to N cells (or hard-drops it),
// committing each position to the collision/map unit and waiting for its acknowledge.
package executor_move_multi_pkg;
  typedef enum logic [1:0] {
    eNonDir = 2'd0,
    eDown   = 2'd1,
    eLeft   = 2'd2,
    eRight  = 2'd3
  } direction_e;
endpackage

module executor_move_multi
  import executor_move_multi_pkg::*;
#(
  parameter int unsigned width_p     = 16,
  parameter int unsigned height_p    = 32,
  parameter int unsigned max_steps_p = 7,
  parameter int unsigned debug_p     = 0,
  localparam int unsigned XWidth     = $clog2(width_p) + 1,
  localparam int unsigned YWidth     = $clog2(height_p) + 1,
  localparam int unsigned StepWidth  = $clog2(height_p + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  direction_e               direction_i,
  input  logic [StepWidth-1:0]     steps_i,
  input  logic                     hard_drop_i,
  // Positions are packed as {x, y}.
  input  logic [XWidth+YWidth-1:0] pos_i,
  input  logic [2:0]               move_avail_i,
  input  logic                     cm_is_ready_i,
  output logic [XWidth+YWidth-1:0] new_pos_o,
  output logic                     new_pos_v_o,
  output logic                     done_o,
  output logic [StepWidth-1:0]     steps_taken_o,
  output logic                     blocked_o
);

  typedef enum logic [2:0] {StIdle, StCheck, StWrite, StWait, StDone} state_e;

  state_e                 state_q, state_d;
  direction_e             dir_q, dir_d;
  logic [XWidth-1:0]      x_q, x_d;
  logic [YWidth-1:0]      y_q, y_d;
  logic [StepWidth-1:0]   remaining_q, remaining_d;
  logic [StepWidth-1:0]   steps_q, steps_d;
  logic                   blocked_q, blocked_d;
  logic                   hard_q, hard_d;
  logic                   avail_sel;
  logic [StepWidth-1:0]   steps_clamped;

  // State tracing is left to the simulator; the parameter only keeps the interface stable.
  logic unused_debug;
  assign unused_debug = ^debug_p;

  assign steps_clamped = (steps_i > StepWidth'(max_steps_p)) ? StepWidth'(max_steps_p) : steps_i;

  always_comb begin
    avail_sel = 1'b0;
    unique case (dir_q)
      eLeft:   avail_sel = move_avail_i[0];
      eRight:  avail_sel = move_avail_i[1];
      eDown:   avail_sel = move_avail_i[2];
      default: avail_sel = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    x_d         = x_q;
    y_d         = y_q;
    remaining_d = remaining_q;
    steps_d     = steps_q;
    blocked_d   = blocked_q;
    hard_d      = hard_q;
    unique case (state_q)
      StIdle: begin
        if (v_i) begin
          dir_d       = direction_i;
          x_d         = pos_i[XWidth+YWidth-1:YWidth];
          y_d         = pos_i[YWidth-1:0];
          hard_d      = hard_drop_i && (direction_i == eDown);
          remaining_d = (hard_drop_i && (direction_i == eDown)) ? StepWidth'(height_p)
                                                                 : steps_clamped;
          steps_d     = '0;
          blocked_d   = 1'b0;
          state_d     = StCheck;
        end
      end
      StCheck: begin
        if ((remaining_q == '0) || (dir_q == eNonDir)) begin
          blocked_d = 1'b0;
          state_d   = StDone;
        end else if (!avail_sel) begin
          // A hard drop that already moved has simply landed.
          blocked_d = !(hard_q && (steps_q != '0));
          state_d   = StDone;
        end else begin
          unique case (dir_q)
            eLeft:   x_d = x_q - 1'b1;
            eRight:  x_d = x_q + 1'b1;
            default: y_d = y_q + 1'b1;
          endcase
          state_d = StWrite;
        end
      end
      StWrite: state_d = StWait;
      StWait: begin
        if (cm_is_ready_i) begin
          remaining_d = remaining_q - 1'b1;
          steps_d     = steps_q + 1'b1;
          state_d     = StCheck;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= StIdle;
      dir_q       <= eNonDir;
      x_q         <= '0;
      y_q         <= '0;
      remaining_q <= '0;
      steps_q     <= '0;
      blocked_q   <= 1'b0;
      hard_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      x_q         <= x_d;
      y_q         <= y_d;
      remaining_q <= remaining_d;
      steps_q     <= steps_d;
      blocked_q   <= blocked_d;
      hard_q      <= hard_d;
    end
  end

  assign ready_o       = (state_q == StIdle);
  assign new_pos_v_o   = (state_q == StWrite);
  assign done_o        = (state_q == StDone);
  assign new_pos_o     = {x_q, y_q};
  assign steps_taken_o = steps_q;
  assign blocked_o     = blocked_q;

endmodule

// File: tb/tb_executor_move_multi.sv
// Self-checking bench for executor_move_multi: scoreboard of expected strobe positions
// plus a collision/map responder that derives move_avail_i from the committed position.
module tb_executor_move_multi;
  import executor_move_multi_pkg::*;

  localparam int XW = 5;
  localparam int YW = 6;
  localparam int SW = 6;
  localparam int Budget = 1000;

  logic              clk_i = 1'b0;
  logic              reset_n_i = 1'b0;
  logic              v_i = 1'b0;
  logic              ready_o;
  direction_e        direction_i = eNonDir;
  logic [SW-1:0]     steps_i = '0;
  logic              hard_drop_i = 1'b0;
  logic [XW+YW-1:0]  pos_i = '0;
  logic [2:0]        move_avail_i;
  logic              cm_is_ready_i = 1'b0;
  logic [XW+YW-1:0]  new_pos_o;
  logic              new_pos_v_o;
  logic              done_o;
  logic [SW-1:0]     steps_taken_o;
  logic              blocked_o;

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;
  int gen = 0;
  int resp_gen;
  int cm_delay = 0;
  bit glitch = 1'b0;
  logic [XW+YW-1:0] exp_q[$];
  logic [XW+YW-1:0] cur_pos = '0;
  logic [XW+YW-1:0] exp_pos;
  int left_min = 0;
  int right_max = 15;
  int down_max = 63;

  executor_move_multi dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .v_i           (v_i),
    .ready_o       (ready_o),
    .direction_i   (direction_i),
    .steps_i       (steps_i),
    .hard_drop_i   (hard_drop_i),
    .pos_i         (pos_i),
    .move_avail_i  (move_avail_i),
    .cm_is_ready_i (cm_is_ready_i),
    .new_pos_o     (new_pos_o),
    .new_pos_v_o   (new_pos_v_o),
    .done_o        (done_o),
    .steps_taken_o (steps_taken_o),
    .blocked_o     (blocked_o)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    move_avail_i    = 3'b000;
    move_avail_i[0] = int'(cur_pos[XW+YW-1:YW]) > left_min;
    move_avail_i[1] = int'(cur_pos[XW+YW-1:YW]) < right_max;
    move_avail_i[2] = int'(cur_pos[YW-1:0]) < down_max;
  end

  function automatic logic [XW+YW-1:0] mk(input int x, input int y);
    mk = {XW'(x), YW'(y)};
  endfunction

  // Scoreboard: every strobe pops one expected position.
  always @(negedge clk_i) begin
    if (reset_n_i && new_pos_v_o) begin
      strobe_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL strobe_extra: got pos=%h, none expected", new_pos_o);
      end else begin
        exp_pos = exp_q.pop_front();
        if (new_pos_o !== exp_pos) begin
          bad++;
          $display("FAIL strobe_pos: got %h want %h", new_pos_o, exp_pos);
        end
      end
    end
  end

  // Collision/map responder: acknowledges each write after cm_delay WAIT cycles.
  always @(negedge clk_i) begin
    if (reset_n_i && new_pos_v_o) begin
      resp_gen = gen;
      if (glitch) cm_is_ready_i = 1'b1;
      @(negedge clk_i);
      cm_is_ready_i = 1'b0;
      repeat (cm_delay) @(negedge clk_i);
      if (resp_gen == gen) begin
        cm_is_ready_i = 1'b1;
        cur_pos = new_pos_o;
        @(negedge clk_i);
        cm_is_ready_i = 1'b0;
      end
    end
  end

  // Drives one command and waits (bounded) for done_o; lat counts cycles from accept.
  task automatic issue(input direction_e dir, input int steps, input bit hard,
                       input logic [XW+YW-1:0] pos, output int lat, output bit timed_out);
    @(negedge clk_i);
    v_i = 1'b1;
    direction_i = dir;
    steps_i = SW'(steps);
    hard_drop_i = hard;
    pos_i = pos;
    cur_pos = pos;
    @(negedge clk_i);
    v_i = 1'b0;
    lat = 1;
    while (!done_o && lat < Budget) begin
      @(negedge clk_i);
      lat++;
    end
    timed_out = !done_o;
  endtask

  task automatic test_reset();
    total++;
    if ({ready_o, new_pos_v_o, done_o, blocked_o} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_ctl: got rdy/v/done/blk=%b want 1000",
               {ready_o, new_pos_v_o, done_o, blocked_o});
    end
    total++;
    if (new_pos_o !== '0 || steps_taken_o !== '0) begin
      bad++;
      $display("FAIL reset_data: got pos=%h steps=%0d want 0/0", new_pos_o, steps_taken_o);
    end
  endtask

  task automatic test_right();
    int lat;
    bit to;
    cm_delay = 0;
    for (int i = 5; i <= 7; i++) exp_q.push_back(mk(i, 0));
    issue(eRight, 3, 1'b0, mk(4, 0), lat, to);
    total++;
    if (to || steps_taken_o !== 6'd3 || blocked_o !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL right3: got to=%0d steps=%0d blk=%0d left=%0d want 0/3/0/0",
               to, steps_taken_o, blocked_o, exp_q.size());
    end
    @(negedge clk_i);
    total++;
    if (done_o !== 1'b0 || ready_o !== 1'b1 || steps_taken_o !== 6'd3) begin
      bad++;
      $display("FAIL done_pulse: got done=%0d rdy=%0d steps=%0d want 0/1/3",
               done_o, ready_o, steps_taken_o);
    end
  endtask

  task automatic test_left_blocked();
    int lat;
    bit to;
    left_min = 0;
    cm_delay = 1;
    exp_q.push_back(mk(1, 7));
    exp_q.push_back(mk(0, 7));
    issue(eLeft, 5, 1'b0, mk(2, 7), lat, to);
    total++;
    if (to || steps_taken_o !== 6'd2 || blocked_o !== 1'b1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL left_blocked: got to=%0d steps=%0d blk=%0d left=%0d want 0/2/1/0",
               to, steps_taken_o, blocked_o, exp_q.size());
    end
  endtask

  task automatic test_hard_drop();
    int lat;
    bit to;
    down_max = 29;
    cm_delay = 2;
    glitch = 1'b1;
    for (int y = 11; y <= 29; y++) exp_q.push_back(mk(3, y));
    issue(eDown, 3, 1'b1, mk(3, 10), lat, to);
    glitch = 1'b0;
    total++;
    if (to || steps_taken_o !== 6'd19 || blocked_o !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL hard_drop: got to=%0d steps=%0d blk=%0d left=%0d want 0/19/0/0",
               to, steps_taken_o, blocked_o, exp_q.size());
    end
    down_max = 10;
    issue(eDown, 0, 1'b1, mk(3, 10), lat, to);
    total++;
    if (to || lat != 2 || steps_taken_o !== 6'd0 || blocked_o !== 1'b1) begin
      bad++;
      $display("FAIL drop_blocked: got to=%0d lat=%0d steps=%0d blk=%0d want 0/2/0/1",
               to, lat, steps_taken_o, blocked_o);
    end
  endtask

  task automatic test_drop_cap();
    int lat;
    bit to;
    down_max = 63;
    cm_delay = 0;
    for (int y = 1; y <= 32; y++) exp_q.push_back(mk(9, y));
    issue(eDown, 0, 1'b1, mk(9, 0), lat, to);
    total++;
    if (to || steps_taken_o !== 6'd32 || blocked_o !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL drop_cap: got to=%0d steps=%0d blk=%0d left=%0d want 0/32/0/0",
               to, steps_taken_o, blocked_o, exp_q.size());
    end
  endtask

  task automatic test_clamp();
    int lat;
    bit to;
    down_max = 31;
    for (int y = 1; y <= 7; y++) exp_q.push_back(mk(0, y));
    issue(eDown, 12, 1'b0, mk(0, 0), lat, to);
    total++;
    if (to || steps_taken_o !== 6'd7 || blocked_o !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL clamp: got to=%0d steps=%0d blk=%0d left=%0d want 0/7/0/0",
               to, steps_taken_o, blocked_o, exp_q.size());
    end
  endtask

  task automatic test_zero();
    int lat;
    bit to;
    int s0;
    s0 = strobe_cnt;
    issue(eNonDir, 3, 1'b0, mk(5, 5), lat, to);
    total++;
    if (to || lat != 2 || steps_taken_o !== 6'd0 || blocked_o !== 1'b0) begin
      bad++;
      $display("FAIL nondir: got to=%0d lat=%0d steps=%0d blk=%0d want 0/2/0/0",
               to, lat, steps_taken_o, blocked_o);
    end
    issue(eRight, 0, 1'b0, mk(5, 5), lat, to);
    total++;
    if (to || lat != 2 || steps_taken_o !== 6'd0 || strobe_cnt != s0) begin
      bad++;
      $display("FAIL zero_steps: got to=%0d lat=%0d steps=%0d strobes=%0d want 0/2/0/0",
               to, lat, steps_taken_o, strobe_cnt - s0);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit to;
    int n;
    int s0;
    cm_delay = 6;
    right_max = 15;
    for (int i = 4; i <= 8; i++) exp_q.push_back(mk(i, 2));
    s0 = strobe_cnt;
    @(negedge clk_i);
    v_i = 1'b1;
    direction_i = eRight;
    steps_i = 6'd5;
    hard_drop_i = 1'b0;
    pos_i = mk(3, 2);
    cur_pos = mk(3, 2);
    @(negedge clk_i);
    v_i = 1'b0;
    n = 0;
    while (strobe_cnt - s0 < 2 && n < Budget) begin
      @(negedge clk_i);
      n++;
    end
    total++;
    if (strobe_cnt - s0 < 2) begin
      bad++;
      $display("FAIL mid_strobes: got %0d strobes want 2", strobe_cnt - s0);
    end
    @(negedge clk_i);
    reset_n_i = 1'b0;
    gen++;
    exp_q.delete();
    #1;
    total++;
    if ({ready_o, new_pos_v_o, done_o, blocked_o} !== 4'b1000 || new_pos_o !== '0 ||
        steps_taken_o !== '0) begin
      bad++;
      $display("FAIL async_reset: got rdy/v/done/blk=%b pos=%h steps=%0d want 1000/0/0",
               {ready_o, new_pos_v_o, done_o, blocked_o}, new_pos_o, steps_taken_o);
    end
    repeat (2) @(negedge clk_i);
    cm_is_ready_i = 1'b0;
    reset_n_i = 1'b1;
    s0 = strobe_cnt;
    repeat (8) @(negedge clk_i);
    total++;
    if (strobe_cnt != s0 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_idle: got strobes=%0d rdy=%0d want 0/1",
               strobe_cnt - s0, ready_o);
    end
    cm_delay = 0;
    down_max = 31;
    exp_q.push_back(mk(7, 4));
    exp_q.push_back(mk(7, 5));
    issue(eDown, 2, 1'b0, mk(7, 3), lat, to);
    total++;
    if (to || steps_taken_o !== 6'd2 || blocked_o !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL after_reset: got to=%0d steps=%0d blk=%0d left=%0d want 0/2/0/0",
               to, steps_taken_o, blocked_o, exp_q.size());
    end
  endtask

  initial begin
    reset_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    test_reset();
    reset_n_i = 1'b1;
    @(negedge clk_i);
    test_right();
    test_left_blocked();
    test_hard_drop();
    test_drop_cap();
    test_clamp();
    test_zero();
    test_reset_mid();
    repeat (3) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
